// File: rtl/mgmt_sensor_bridge_if.sv
// Byte-level handshake between the management SPI slave core and the sensor bridge.
interface mgmt_sensor_bridge_if;
  logic       spi_rx_data_valid;
  logic [7:0] spi_rx_data;
  logic       spi_cs_falling;
  logic       spi_tx_data_valid;
  logic [7:0] spi_tx_data;

  modport master (
    output spi_rx_data_valid, spi_rx_data, spi_cs_falling,
    input  spi_tx_data_valid, spi_tx_data
  );

  modport slave (
    input  spi_rx_data_valid, spi_rx_data, spi_cs_falling,
    output spi_tx_data_valid, spi_tx_data
  );
endinterface

// File: rtl/mgmt_sensor_bridge.sv
// SPI opcode/index decoder streaming coherent, LSB-first channel snapshots with auto-increment.
// Define MGMT_SENSOR_MINMAX_EN to build per-channel min/max tracking (opcodes 0x03/0x04/0x05).
`ifdef MGMT_SENSOR_MINMAX_EN
module mgmt_sensor_minmax #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         update,
  input  logic [W-1:0] sample,
  output logic [W-1:0] min_q,
  output logic [W-1:0] max_q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clear) begin
      min_q <= '1;
      max_q <= '0;
    end else if (update) begin
      if (sample > max_q) max_q <= sample;
      if (sample < min_q) min_q <= sample;
    end
  end
endmodule
`endif

module mgmt_sensor_bridge #(
  parameter int NUM_CHANNELS = 8,
  parameter int CHAN_WIDTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  mgmt_sensor_bridge_if.slave                spi,
  input  logic [NUM_CHANNELS*CHAN_WIDTH-1:0] chan_in,
  input  logic [NUM_CHANNELS-1:0]            chan_update
);
  localparam int BYTES = CHAN_WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {IDLE, OPCODE, INDEX, DATA, DRAIN} state_t;

  state_t                                 state;
  logic [7:0]                             idx, nxt_idx, b_idx;
  logic [CW-1:0]                          cnt;
  logic [BYTES-1:0][7:0]                  snap, rd_a, rd_b;
  logic [NUM_CHANNELS-1:0][CHAN_WIDTH-1:0] live, src_arr;
  logic                                   rx_ok;

  function automatic logic [7:0] wrap_inc(input logic [7:0] i);
    return (i >= 8'(NUM_CHANNELS - 1)) ? 8'd0 : i + 8'd1;
  endfunction

  assign live    = chan_in;
  assign rx_ok   = spi.spi_rx_data_valid && !spi.spi_cs_falling;
  assign nxt_idx = wrap_inc(idx);
  // Port B always looks one channel ahead so the next snapshot lands on the last-byte edge.
  assign b_idx   = (state == INDEX) ? wrap_inc(spi.spi_rx_data) : nxt_idx;

`ifdef MGMT_SENSOR_MINMAX_EN
  typedef enum logic [1:0] {SRC_LIVE, SRC_MAX, SRC_MIN} src_t;
  src_t                                   src_sel;
  logic [NUM_CHANNELS-1:0][CHAN_WIDTH-1:0] mx, mn;
  logic                                   mm_clear;

  assign mm_clear = rx_ok && (state == OPCODE) && (spi.spi_rx_data == 8'h05);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_mm
    mgmt_sensor_minmax #(.W(CHAN_WIDTH)) u_mm (
      .clk    (clk),
      .rst    (rst),
      .clear  (mm_clear),
      .update (chan_update[g]),
      .sample (live[g]),
      .min_q  (mn[g]),
      .max_q  (mx[g])
    );
    assign src_arr[g] = (src_sel == SRC_MAX) ? mx[g] :
                        (src_sel == SRC_MIN) ? mn[g] : live[g];
  end
`else
  logic unused_chan_update;
  assign unused_chan_update = ^chan_update;
  assign src_arr = live;
`endif

  // Out-of-range indices fall through to the zero default.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (spi.spi_rx_data == 8'(i)) rd_a = src_arr[i];
      if (b_idx == 8'(i))           rd_b = src_arr[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      idx                   <= '0;
      cnt                   <= '0;
      snap                  <= '0;
      spi.spi_tx_data_valid <= 1'b0;
      spi.spi_tx_data       <= 8'h00;
`ifdef MGMT_SENSOR_MINMAX_EN
      src_sel               <= SRC_LIVE;
`endif
    end else begin
      spi.spi_tx_data_valid <= 1'b0;
      if (spi.spi_cs_falling) begin
        state <= OPCODE;
      end else if (spi.spi_rx_data_valid) begin
        case (state)
          OPCODE: begin
            case (spi.spi_rx_data)
              8'h01: begin
                state <= INDEX;
`ifdef MGMT_SENSOR_MINMAX_EN
                src_sel <= SRC_LIVE;
`endif
              end
              8'h02: begin
                spi.spi_tx_data_valid <= 1'b1;
                spi.spi_tx_data       <= 8'(NUM_CHANNELS);
                state                 <= DRAIN;
              end
`ifdef MGMT_SENSOR_MINMAX_EN
              8'h03: begin src_sel <= SRC_MAX; state <= INDEX; end
              8'h04: begin src_sel <= SRC_MIN; state <= INDEX; end
`endif
              default: state <= DRAIN;
            endcase
          end
          INDEX: begin
            spi.spi_tx_data_valid <= 1'b1;
            spi.spi_tx_data       <= rd_a[0];
            state                 <= DATA;
            if (BYTES == 1) begin
              idx  <= b_idx;
              snap <= rd_b;
              cnt  <= '0;
            end else begin
              idx  <= spi.spi_rx_data;
              snap <= rd_a;
              cnt  <= CW'(1);
            end
          end
          DATA: begin
            spi.spi_tx_data_valid <= 1'b1;
            spi.spi_tx_data       <= snap[cnt];
            if (cnt == CW'(BYTES - 1)) begin
              idx  <= nxt_idx;
              snap <= rd_b;
              cnt  <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DRAIN: begin
            spi.spi_tx_data_valid <= 1'b1;
            spi.spi_tx_data       <= 8'h00;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
